a2d_intf: RTL and testbench
===========================

Name: a2d_intf

Overview:
- SPI-master responder to the slide interface's conversion handshake.
- Accepts strt_cnv/chnnl from slide_intf and runs two 16-bit SPI frames on the external 8-channel 12-bit A2D.
  - Frame 1 selects the channel.
  - Frame 2 repeats the command and returns the conversion.
- Returns the result on res and signals cnv_cmplt.
- Sits between slide_intf and the A2D pins (a2d_SS_n, SCLK, MOSI, MISO).

Parameters:
- DIV_W, 5, SCLK divider width; SCLK period = 2^DIV_W clk (32).
- GAP_CYC, 4, clk cycles SS_n held high between frame 1 and frame 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- strt_cnv  input  1  single-cycle request to start a conversion
- chnnl  input  3  channel to convert; sampled with strt_cnv
- cnv_cmplt  output  1  conversion done; level, held until next accepted strt_cnv
- res  output  12  conversion result; holds last value
- a2d_SS_n  output  1  A2D chip select, active low
- SCLK  output  1  SPI clock; idles high
- MOSI  output  1  SPI data to A2D
- MISO  input  1  SPI data from A2D

Behaviour:
- All outputs registered. Reset (async, rst_n=0) values:
  - a2d_SS_n=1, SCLK=1, MOSI=0, cnv_cmplt=0, res=12'h000.
  - State returns to IDLE, divider counter = 5'b10111.
- States: IDLE, FRM1, GAP, FRM2.
  - IDLE: on strt_cnv=1:
    - latch chnnl; load tx shifter with {2'b00, chnnl, 11'h000}.
    - cnv_cmplt<=0, SS_n<=0, divider<=5'b10111; go FRM1.
  - FRM1/FRM2: divider increments every clk; SCLK = divider MSB.
    - Rise edge = the clk edge on which divider goes 01111->10000.
      - On that edge, MISO shifts into rx[0] (rx <= {rx[14:0], MISO}) and the rise count increments.
    - Fall edge = the edge on which divider goes 11111->00000.
      - On every fall edge except the first of a frame, tx shifts left (zero fill).
    - MOSI = tx[15] at all times in a frame. The first bit is valid before the first rise.
    - First fall occurs 9 clk after SS_n falls. A frame holds 16 rises.
    - The frame ends on the first wrap (11111->00000) after the 16th rise. On that edge:
      - SS_n<=1, divider<=5'b10111 (SCLK high).
    - SS_n is low exactly 521 clk per frame.
  - FRM1 end -> GAP: SS_n high for GAP_CYC clk.
    - Then reload tx with the same command, SS_n<=0, go FRM2.
  - FRM2 end -> IDLE. On that same edge: res<=rx[11:0], cnv_cmplt<=1.
- Latency (default parameters), with strt_cnv sampled at edge 0:
  - SS_n falls after edge 0, rises after edge 521.
  - SS_n falls again after edge 525.
  - cnv_cmplt=1 and res valid after edge 1046.
- Boundary conditions:
  - strt_cnv outside IDLE is ignored: no restart, latched chnnl unchanged.
  - strt_cnv in IDLE while cnv_cmplt=1 clears cnv_cmplt on the next edge; res holds its old value until the new conversion ends.
  - Frame-1 rx data is discarded; rx is cleared at the start of each frame.
  - rst_n asserted mid-frame: immediate return to reset values. No partial result reaches res.
  - MOSI=0 outside frames.

Test Plan:
- Reset: rst_n=0 -> SS_n=1, SCLK=1, cnv_cmplt=0, res=0 with no clk edge required. Release with strt_cnv=0 for 100 clk -> outputs unchanged.
- Channel encode: strt_cnv pulse, chnnl=3 -> MOSI sampled at SCLK rises reads 16'h1800 in both frames. Exactly 16 SCLK rises per frame; SS_n low 521 clk, high 4 clk between frames.
- Result capture: A2D model drives 16'h0ABC in frame 2 and 16'hFFFF in frame 1 (MSB first, changing on SCLK fall) -> cnv_cmplt rises exactly 1046 clk after strt_cnv edge, res=12'hABC.
- Busy ignore: second strt_cnv with chnnl=6 at clk 300 -> frame-2 MOSI still 16'h1800, single cnv_cmplt at 1046.
- Re-start: with cnv_cmplt=1, res=12'hABC, pulse strt_cnv with chnnl=7 -> cnv_cmplt=0 next clk, res stays 12'hABC until new completion, then updates; MOSI word 16'h3800.
- Reset mid-operation: rst_n low at clk 700 (in FRM2 window) for 40 ns -> SS_n=1, SCLK=1 immediately, cnv_cmplt=0, res=0. A fresh strt_cnv then completes normally.

Source files
------------

// File: rtl/a2d_intf.sv
// a2d_intf: SPI master that runs the two-frame conversion handshake with an
// external 8-channel 12-bit A2D. Frame 1 selects the channel. Frame 2 repeats
// the command and returns the conversion. The result is presented on res and
// cnv_cmplt is raised as a level.
module a2d_intf #(
    parameter int DIV_W   = 5,
    parameter int GAP_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    output logic        cnv_cmplt,
    output logic [11:0] res,
    output logic        a2d_SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    // Divider preload 10..0111 keeps SCLK high and places the first SCLK fall
    // a few clocks after SS_n drops, which gives MOSI setup time.
    localparam logic [DIV_W-1:0] DIV_INIT = {2'b10, {(DIV_W-2){1'b1}}};
    localparam logic [DIV_W-1:0] DIV_RISE = {1'b0, {(DIV_W-1){1'b1}}};
    localparam int               GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {IDLE, FRM1, GAP, FRM2} state_t;

    state_t           r_state, w_state_next;
    logic [DIV_W-1:0] r_div, w_div_next;
    logic [4:0]       r_rise_cnt, w_rise_next;
    logic [15:0]      r_tx, w_tx_next;
    // Only the low 12 received bits can ever reach res. Older bits are
    // shifted out of the top of the register.
    logic [11:0]      r_rx, w_rx_next;
    logic [GW-1:0]    r_gap_cnt, w_gap_next;
    logic [2:0]       r_chnnl, w_chnnl_next;
    logic             r_ss_n, w_ss_next;
    logic             r_cnv_cmplt, w_cnv_next;
    logic [11:0]      r_res, w_res_next;

    logic             w_in_frame, w_rise, w_fall, w_end;

    assign w_in_frame = (r_state == FRM1) || (r_state == FRM2);
    assign w_rise     = w_in_frame && (r_div == DIV_RISE);
    assign w_fall     = w_in_frame && (&r_div);
    assign w_end      = w_fall && (r_rise_cnt == 5'd16);

    assign cnv_cmplt = r_cnv_cmplt;
    assign res       = r_res;
    assign a2d_SS_n  = r_ss_n;
    assign SCLK      = r_div[DIV_W-1];
    assign MOSI      = r_tx[15];

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div;
        w_rise_next  = r_rise_cnt;
        w_tx_next    = r_tx;
        w_rx_next    = r_rx;
        w_gap_next   = r_gap_cnt;
        w_chnnl_next = r_chnnl;
        w_ss_next    = r_ss_n;
        w_cnv_next   = r_cnv_cmplt;
        w_res_next   = r_res;
        case (r_state)
            IDLE: begin
                if (strt_cnv) begin
                    w_chnnl_next = chnnl;
                    w_tx_next    = {2'b00, chnnl, 11'h000};
                    w_rx_next    = '0;
                    w_rise_next  = '0;
                    w_cnv_next   = 1'b0;
                    w_ss_next    = 1'b0;
                    w_div_next   = DIV_INIT;
                    w_state_next = FRM1;
                end
            end
            FRM1, FRM2: begin
                w_div_next = r_div + 1'b1;
                if (w_rise) begin
                    w_rx_next   = {r_rx[10:0], MISO};
                    w_rise_next = r_rise_cnt + 5'd1;
                end
                // The first fall of a frame comes before any rise, so MOSI
                // keeps the command MSB until that bit has been sampled.
                if (w_fall && (r_rise_cnt != 5'd0)) begin
                    w_tx_next = {r_tx[14:0], 1'b0};
                end
                if (w_end) begin
                    w_ss_next  = 1'b1;
                    w_div_next = DIV_INIT;
                    w_tx_next  = '0;
                    if (r_state == FRM1) begin
                        w_gap_next   = '0;
                        w_state_next = GAP;
                    end else begin
                        w_res_next   = r_rx;
                        w_cnv_next   = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_tx_next    = {2'b00, r_chnnl, 11'h000};
                    w_rx_next    = '0;
                    w_rise_next  = '0;
                    w_ss_next    = 1'b0;
                    w_state_next = FRM2;
                end else begin
                    w_gap_next = r_gap_cnt + 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State and output registers, with asynchronous reset to the idle values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_div       <= DIV_INIT;
            r_rise_cnt  <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_gap_cnt   <= '0;
            r_chnnl     <= '0;
            r_ss_n      <= 1'b1;
            r_cnv_cmplt <= 1'b0;
            r_res       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_div       <= w_div_next;
            r_rise_cnt  <= w_rise_next;
            r_tx        <= w_tx_next;
            r_rx        <= w_rx_next;
            r_gap_cnt   <= w_gap_next;
            r_chnnl     <= w_chnnl_next;
            r_ss_n      <= w_ss_next;
            r_cnv_cmplt <= w_cnv_next;
            r_res       <= w_res_next;
        end
    end

endmodule

// File: tb/tb_a2d_intf.sv
// Testbench for a2d_intf. It uses an A2D pin model and a timing and result
// reference that is computed from the SPI frame rules.
module tb_a2d_intf;

    localparam int DIV_W      = 5;
    localparam int GAP_CYC    = 4;
    localparam int PERIOD     = 1 << DIV_W;                 // SCLK period in clk
    localparam int FIRST_FALL = PERIOD - 23;                // preload 10111 -> wrap
    localparam int FRAME      = FIRST_FALL + 16 * PERIOD;   // SS_n low clocks
    localparam int DONE       = 2 * FRAME + GAP_CYC;        // strt edge -> cnv_cmplt

    logic        clk = 1'b0;
    logic        rst_n;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        a2d_SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    int checks = 0;
    int errors = 0;

    a2d_intf #(.DIV_W(DIV_W), .GAP_CYC(GAP_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .a2d_SS_n  (a2d_SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // A2D model: it presents the word MSB first when SS_n falls. It shifts on
    // each SCLK fall after the first one in the frame. It also records the
    // MOSI bits seen at SCLK rises.
    logic [15:0] a2d_w1, a2d_w2, a2d_sh, mosi_acc;
    int          frm_no, rise_acc;
    bit          a2d_first;
    logic [15:0] q_mosi[$];
    int          q_rise[$];

    always @(negedge a2d_SS_n) begin
        frm_no++;
        a2d_sh    = (frm_no == 1) ? a2d_w1 : a2d_w2;
        a2d_first = 1'b1;
        MISO      = a2d_sh[15];
        mosi_acc  = '0;
        rise_acc  = 0;
    end

    always @(negedge SCLK) begin
        if (!a2d_SS_n) begin
            if (a2d_first) a2d_first = 1'b0;
            else begin
                a2d_sh = {a2d_sh[14:0], 1'b0};
                MISO   = a2d_sh[15];
            end
        end
    end

    always @(posedge SCLK) begin
        if (!a2d_SS_n) begin
            mosi_acc = {mosi_acc[14:0], MOSI};
            rise_acc++;
        end
    end

    always @(posedge a2d_SS_n) begin
        if (rst_n) begin
            q_mosi.push_back(mosi_acc);
            q_rise.push_back(rise_acc);
        end
    end

    logic [11:0] model_res;

    // One conversion. It strobes strt_cnv and observes every clock up to
    // completion. If abort_at >= 0, reset is asserted at that cycle instead.
    task automatic run_conv(input logic [2:0] ch, input logic [15:0] w1, input logic [15:0] w2,
                            input bit busy_poke, input int abort_at);
        int ss_rise1, ss_fall2, ss_rise2, cnv_at, res_bad, mosi_bad;
        logic prev_ss;
        logic [15:0] exp_cmd;
        ss_rise1 = -1; ss_fall2 = -1; ss_rise2 = -1; cnv_at = -1;
        res_bad = 0; mosi_bad = 0;
        exp_cmd = {2'b00, ch, 11'h000};
        q_mosi.delete(); q_rise.delete();
        a2d_w1 = w1; a2d_w2 = w2; frm_no = 0;
        @(negedge clk); strt_cnv = 1'b1; chnnl = ch;
        @(negedge clk); strt_cnv = 1'b0; chnnl = 3'($urandom);
        chk("cnv_clr", {31'd0, cnv_cmplt}, 0);
        chk("ss_fall", {31'd0, a2d_SS_n}, 0);
        prev_ss = 1'b0;
        for (int k = 0; k < DONE + 100; k++) begin
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_ss", {31'd0, a2d_SS_n}, 1);
                chk("rst_sclk", {31'd0, SCLK}, 1);
                chk("rst_cnv", {31'd0, cnv_cmplt}, 0);
                chk("rst_res", {20'd0, res}, 0);
                model_res = '0;
                #39 rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            if (!prev_ss && a2d_SS_n && ss_rise1 < 0) ss_rise1 = k;
            else if (prev_ss && !a2d_SS_n && ss_fall2 < 0) ss_fall2 = k;
            else if (!prev_ss && a2d_SS_n && ss_fall2 >= 0 && ss_rise2 < 0) ss_rise2 = k;
            if (a2d_SS_n && MOSI) mosi_bad++;
            if (!cnv_cmplt && res !== model_res) res_bad++;
            if (cnv_cmplt && cnv_at < 0) cnv_at = k;
            if (busy_poke && k == 300) begin strt_cnv = 1'b1; chnnl = 3'd6; end
            else strt_cnv = 1'b0;
            prev_ss = a2d_SS_n;
            if (cnv_at >= 0 && k >= cnv_at + 20) break;
            if (cnv_at >= 0) chk("cnv_hold", {31'd0, cnv_cmplt & a2d_SS_n}, 1);
            @(negedge clk);
        end
        model_res = w2[11:0];
        chk("ss_low1", ss_rise1, FRAME);
        chk("gap", ss_fall2 - ss_rise1, GAP_CYC);
        chk("ss_low2", ss_rise2 - ss_fall2, FRAME);
        chk("done_lat", cnv_at, DONE);
        chk("res", {20'd0, res}, {20'd0, model_res});
        chk("res_hold", res_bad, 0);
        chk("mosi_idle", mosi_bad, 0);
        chk("frames", q_mosi.size(), 2);
        for (int f = 0; f < q_mosi.size() && f < 2; f++) begin
            chk("mosi_word", {16'd0, q_mosi[f]}, {16'd0, exp_cmd});
            chk("rises", q_rise[f], 16);
        end
        $display("conv ch=%0d w1=%h w2=%h res=%h lat=%0d", ch, w1, w2, res, cnv_at);
    endtask

    initial begin
        int idle_bad;
        logic [2:0] rch;
        strt_cnv = 1'b0; chnnl = '0; MISO = 1'b0; model_res = '0;
        a2d_w1 = '0; a2d_w2 = '0; frm_no = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("por_ss", {31'd0, a2d_SS_n}, 1);
        chk("por_sclk", {31'd0, SCLK}, 1);
        chk("por_cnv", {31'd0, cnv_cmplt}, 0);
        chk("por_res", {20'd0, res}, 0);
        chk("por_mosi", {31'd0, MOSI}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a2d_SS_n !== 1'b1 || SCLK !== 1'b1 || cnv_cmplt !== 1'b0 ||
                res !== 12'h000 || MOSI !== 1'b0) idle_bad++;
        end
        chk("idle_stable", idle_bad, 0);
        $display("reset/idle done");

        // Channel encode, result capture and busy ignore.
        run_conv(3'd3, 16'hFFFF, 16'h0ABC, 1'b1, -1);
        // Restart while complete: res must hold 12'hABC until the new result.
        run_conv(3'd7, 16'($urandom), 16'($urandom), 1'b0, -1);

        // Randomized conversions with random idle spacing.
        for (int n = 0; n < 5; n++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            rch = 3'($urandom_range(0, 7));
            run_conv(rch, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), -1);
        end

        // Reset during frame 2, then a fresh conversion.
        run_conv(3'd5, 16'h1234, 16'h0FED, 1'b0, 700);
        chk("post_rst_ss", {31'd0, a2d_SS_n}, 1);
        run_conv(3'd2, 16'($urandom), 16'h0555, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
